// File: rtl/step_pkg.sv
// Shared types and default widths for the step scheduler.
// Holds the FSM state encoding and the default count/time widths.
package step_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int TIME_W_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick.
// Ports: i_elig_a/i_elig_b eligibility, i_prio_b priority holder (0=A), o_pick_a/o_pick_b one-hot pick.
module rr_arb2 (
  input  logic i_elig_a,
  input  logic i_elig_b,
  input  logic i_prio_b,
  output logic o_pick_a,
  output logic o_pick_b
);

  // A lone eligible channel always wins; a tie goes to the priority holder.
  assign o_pick_a = i_elig_a & (~i_elig_b | ~i_prio_b);
  assign o_pick_b = i_elig_b & (~i_elig_a |  i_prio_b);

endmodule

// File: rtl/step_scheduler.sv
// Two-channel step scheduler: runs count_a/count_b steps with round-robin grants.
// Ports: start/count_a/count_b begin a run; req_a/req_b request steps; gnt_a/gnt_b/idx grant; time_cnt/busy/done status.
module step_scheduler
  import step_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  count_a,
  input  logic [CNT_W-1:0]  count_b,
  input  logic              req_a,
  input  logic              req_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic [CNT_W-1:0]  idx,
  output logic [TIME_W-1:0] time_cnt,
  output logic              busy,
  output logic              done
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt_a;
  logic [CNT_W-1:0]   r_cnt_b;
  logic [CNT_W-1:0]   r_iss_a;
  logic [CNT_W-1:0]   r_iss_b;
  logic [CNT_W-1:0]   r_idx;
  logic [TIME_W-1:0]  r_time;
  logic               r_prio_b;
  logic               r_gnt_a;
  logic               r_gnt_b;

  logic               w_run;
  logic               w_elig_a;
  logic               w_elig_b;
  logic               w_pick_a;
  logic               w_pick_b;
  logic [CNT_W-1:0]   w_iss_a_nxt;
  logic [CNT_W-1:0]   w_iss_b_nxt;
  logic               w_fin;

  assign w_run    = (r_state == S_RUN);
  assign w_elig_a = w_run & req_a & (r_iss_a < r_cnt_a);
  assign w_elig_b = w_run & req_b & (r_iss_b < r_cnt_b);

  rr_arb2 u_arb (
    .i_elig_a (w_elig_a),
    .i_elig_b (w_elig_b),
    .i_prio_b (r_prio_b),
    .o_pick_a (w_pick_a),
    .o_pick_b (w_pick_b)
  );

  assign w_iss_a_nxt = r_iss_a + CNT_W'(w_pick_a);
  assign w_iss_b_nxt = r_iss_b + CNT_W'(w_pick_b);
  // Completion counts the grant being issued this cycle.
  assign w_fin = (w_iss_a_nxt == r_cnt_a) && (w_iss_b_nxt == r_cnt_b);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_fin) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt_a  <= '0;
      r_cnt_b  <= '0;
      r_iss_a  <= '0;
      r_iss_b  <= '0;
      r_idx    <= '0;
      r_time   <= '0;
      r_prio_b <= 1'b0;
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt_a <= w_pick_a;
      r_gnt_b <= w_pick_b;
      if (r_state == S_IDLE && start) begin
        r_cnt_a  <= count_a;
        r_cnt_b  <= count_b;
        r_iss_a  <= '0;
        r_iss_b  <= '0;
        r_time   <= '0;
        r_prio_b <= 1'b0;
      end
      if (w_run) begin
        r_iss_a <= w_iss_a_nxt;
        r_iss_b <= w_iss_b_nxt;
        r_time  <= r_time + 1'b1;
        if (w_pick_a) begin
          r_prio_b <= 1'b1;
          r_idx    <= r_iss_a;
        end else if (w_pick_b) begin
          r_prio_b <= 1'b0;
          r_idx    <= r_iss_b;
        end
      end
    end
  end

  assign gnt_a    = r_gnt_a;
  assign gnt_b    = r_gnt_b;
  assign idx      = r_idx;
  assign time_cnt = r_time;
  assign busy     = w_run;
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_step_scheduler.sv
// Directed self-checking bench for step_scheduler.
// Each scenario task drives a run and checks grants, indices, done and time.
module tb_step_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  count_a = '0;
  logic [7:0]  count_b = '0;
  logic        req_a = 1'b1;
  logic        req_b = 1'b1;
  logic        gnt_a;
  logic        gnt_b;
  logic [7:0]  idx;
  logic [31:0] time_cnt;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;

  string seq;
  string idxs;
  int    done_cnt;
  int    done_at;
  int    done_tc;
  int    tc_after;
  int    both_hi;
  int    busy1;
  int    busy_after;
  int    timeout;
  int    rb_release = -10;
  int    rs_at = -10;

  always #5 clk = ~clk;

  step_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .count_a  (count_a),
    .count_b  (count_b),
    .req_a    (req_a),
    .req_b    (req_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .idx      (idx),
    .time_cnt (time_cnt),
    .busy     (busy),
    .done     (done)
  );

  task automatic run(input logic [7:0] ca, input logic [7:0] cb);
    seq = ""; idxs = "";
    done_cnt = 0; done_at = -1; done_tc = -1;
    tc_after = -1; both_hi = 0; busy1 = -1;
    busy_after = -1; timeout = 1;
    @(negedge clk);
    count_a = ca; count_b = cb; start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        busy1 = int'(busy);
      end
      if (gnt_a && gnt_b) both_hi++;
      if (gnt_a) begin
        seq = {seq, "A"};
        idxs = {idxs, $sformatf("%0d,", idx)};
      end
      if (gnt_b) begin
        seq = {seq, "B"};
        idxs = {idxs, $sformatf("%0d,", idx)};
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c;
          done_tc = int'(time_cnt);
        end
      end
      if (done_at >= 0 && c == done_at + 1) begin
        busy_after = int'(busy);
        tc_after = int'(time_cnt);
      end
      if (c == rb_release) req_b = 1'b1;
      if (c == rs_at) begin
        count_a = 8'd9; count_b = 8'd9; start = 1'b1;
      end
      if (c == rs_at + 1) start = 1'b0;
      if (done_at >= 0 && c >= done_at + 3) begin
        timeout = 0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    total++;
    if ({gnt_a, gnt_b, idx, time_cnt, busy, done} !== 44'd0) begin
      bad++;
      $display("FAIL reset_outputs got ga=%b gb=%b idx=%0d t=%0d busy=%b done=%b want all 0",
               gnt_a, gnt_b, idx, time_cnt, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle busy=%b want 0", busy);
    end
  endtask

  task automatic test_alternate;
    string es;
    string ei;
    es = ""; ei = "";
    for (int i = 0; i < 10; i++) begin
      es = {es, "AB"};
      ei = {ei, $sformatf("%0d,%0d,", i, i)};
    end
    run(8'd10, 8'd10);
    total++;
    if (timeout !== 0) begin bad++; $display("FAIL alt_timeout no done seen"); end
    total++;
    if (busy1 !== 1) begin bad++; $display("FAIL alt_busy got %0d want 1", busy1); end
    total++;
    if (seq != es) begin bad++; $display("FAIL alt_seq got %s want %s", seq, es); end
    total++;
    if (idxs != ei) begin bad++; $display("FAIL alt_idx got %s want %s", idxs, ei); end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL alt_done_cnt got %0d want 1", done_cnt); end
    total++;
    if (done_at !== 21) begin bad++; $display("FAIL alt_done_at got %0d want 21", done_at); end
    total++;
    if (done_tc !== 20) begin bad++; $display("FAIL alt_time got %0d want 20", done_tc); end
    total++;
    if (tc_after !== 20) begin bad++; $display("FAIL alt_time_hold got %0d want 20", tc_after); end
    total++;
    if (busy_after !== 0) begin bad++; $display("FAIL alt_idle busy got %0d want 0", busy_after); end
    total++;
    if (both_hi !== 0) begin bad++; $display("FAIL alt_both_gnt got %0d want 0", both_hi); end
  endtask

  task automatic test_uneven;
    run(8'd3, 8'd5);
    total++;
    if (seq != "ABABABBB") begin bad++; $display("FAIL uneven_seq got %s want ABABABBB", seq); end
    total++;
    if (idxs != "0,0,1,1,2,2,3,4,") begin
      bad++; $display("FAIL uneven_idx got %s want 0,0,1,1,2,2,3,4,", idxs);
    end
    total++;
    if (done_at !== 9 || done_cnt !== 1) begin
      bad++; $display("FAIL uneven_done at=%0d cnt=%0d want at=9 cnt=1", done_at, done_cnt);
    end
    total++;
    if (done_tc !== 8) begin bad++; $display("FAIL uneven_time got %0d want 8", done_tc); end
  endtask

  task automatic test_zero;
    run(8'd0, 8'd0);
    total++;
    if (seq != "") begin bad++; $display("FAIL zero_seq got %s want none", seq); end
    total++;
    if (done_at !== 2 || done_cnt !== 1) begin
      bad++; $display("FAIL zero_done at=%0d cnt=%0d want at=2 cnt=1", done_at, done_cnt);
    end
    total++;
    if (done_tc !== 1) begin bad++; $display("FAIL zero_time got %0d want 1", done_tc); end
    total++;
    if (tc_after !== 1) begin bad++; $display("FAIL zero_time_hold got %0d want 1", tc_after); end
  endtask

  task automatic test_stall_b;
    req_b = 1'b0;
    rb_release = 7;
    run(8'd4, 8'd4);
    rb_release = -10;
    req_b = 1'b1;
    total++;
    if (seq != "AAAABBBB") begin bad++; $display("FAIL stall_seq got %s want AAAABBBB", seq); end
    total++;
    if (idxs != "0,1,2,3,0,1,2,3,") begin
      bad++; $display("FAIL stall_idx got %s want 0,1,2,3,0,1,2,3,", idxs);
    end
    total++;
    if (done_at !== 11 || done_cnt !== 1) begin
      bad++; $display("FAIL stall_done at=%0d cnt=%0d want at=11 cnt=1", done_at, done_cnt);
    end
    total++;
    if (done_tc !== 10) begin bad++; $display("FAIL stall_time got %0d want 10", done_tc); end
  endtask

  task automatic test_mid_reset;
    int g;
    int d;
    g = 0; d = 0;
    @(negedge clk);
    count_a = 8'd10; count_b = 8'd10; start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (gnt_a || gnt_b) g++;
    end
    total++;
    if (g !== 5) begin bad++; $display("FAIL mrst_pre_grants got %0d want 5", g); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({gnt_a, gnt_b, idx, time_cnt, busy, done} !== 44'd0) begin
      bad++;
      $display("FAIL mrst_outputs got ga=%b gb=%b idx=%0d t=%0d busy=%b done=%b want all 0",
               gnt_a, gnt_b, idx, time_cnt, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    g = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (gnt_a || gnt_b || busy) g++;
      if (done) d++;
    end
    total++;
    if (g !== 0 || d !== 0) begin
      bad++; $display("FAIL mrst_quiet activity=%0d done=%0d want 0 0", g, d);
    end
    run(8'd2, 8'd2);
    total++;
    if (seq != "ABAB" || idxs != "0,0,1,1,") begin
      bad++; $display("FAIL mrst_rerun got %s %s want ABAB 0,0,1,1,", seq, idxs);
    end
    total++;
    if (done_at !== 5 || done_tc !== 4 || done_cnt !== 1) begin
      bad++;
      $display("FAIL mrst_rerun_done at=%0d t=%0d cnt=%0d want 5 4 1", done_at, done_tc, done_cnt);
    end
  endtask

  task automatic test_restart_ignored;
    rs_at = 3;
    run(8'd2, 8'd3);
    rs_at = -10;
    total++;
    if (seq != "ABABB" || idxs != "0,0,1,1,2,") begin
      bad++; $display("FAIL restart_seq got %s %s want ABABB 0,0,1,1,2,", seq, idxs);
    end
    total++;
    if (done_at !== 6 || done_tc !== 5 || done_cnt !== 1) begin
      bad++;
      $display("FAIL restart_done at=%0d t=%0d cnt=%0d want 6 5 1", done_at, done_tc, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_uneven();
    test_zero();
    test_stall_b();
    test_mid_reset();
    test_restart_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/step_scheduler.md
STEP_SCHEDULER -- requirements
Module: step_scheduler

Interface
REQ-001 Parameter CNT_W, default 8: width of iteration counts and indices.
REQ-002 Parameter TIME_W, default 32: width of the run-time cycle counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin a run; sampled only in IDLE.
REQ-006 count_a  input  CNT_W  iteration count for channel A; latched on accepted start.
REQ-007 count_b  input  CNT_W  iteration count for channel B; latched on accepted start.
REQ-008 req_a  input  1  channel A ready to take a step.
REQ-009 req_b  input  1  channel B ready to take a step.
REQ-010 gnt_a  output  1  registered one-cycle grant to channel A.
REQ-011 gnt_b  output  1  registered one-cycle grant to channel B.
REQ-012 idx  output  CNT_W  0-based iteration index of the granted step; valid while gnt_a or gnt_b is high.
REQ-013 time_cnt  output  TIME_W  cycles elapsed in the current or most recent run.
REQ-014 busy  output  1  high in RUN.
REQ-015 done  output  1  one-cycle pulse at the end of a run.

Function
REQ-016 FSM states: IDLE, RUN, DONE.
REQ-017 IDLE -> RUN when start=1; latch count_a and count_b, clear both issued-step counters, clear time_cnt, set round-robin priority to A.
REQ-018 In RUN, channel X is eligible when req_x=1 and issued_x < count_x.
REQ-019 Each RUN cycle grants at most one eligible channel: if only one is eligible, grant it; if both are eligible, grant the priority holder.
REQ-020 After any grant, priority passes to the other channel; with no grant, priority holds.
REQ-021 A grant decision made in cycle N appears on gnt_x and idx in cycle N+1 (latency 1); idx equals issued_x before its increment.
REQ-022 gnt_a and gnt_b are never high together; both are low outside RUN, except for the final grant registered on the last RUN cycle.
REQ-023 time_cnt increments by 1 every RUN cycle, holds in IDLE and DONE, and wraps modulo 2^TIME_W.
REQ-024 RUN -> DONE on the cycle in which issued_a = count_a and issued_b = count_b, counting any grant issued that cycle.
REQ-025 count_a = count_b = 0: RUN lasts one cycle with no grants, then DONE.
REQ-026 DONE lasts one cycle with done=1, then returns to IDLE.
REQ-027 start is ignored in RUN and DONE; changes to count_a and count_b after latching have no effect.
REQ-028 A withdrawn request (req_x low) only stalls channel X; the other channel keeps being granted every cycle it is eligible.

Reset
REQ-029 rst_n=0 immediately forces IDLE; gnt_a=0, gnt_b=0, idx=0, time_cnt=0, busy=0, done=0; counters cleared; priority set to A.
REQ-030 Reset asserted mid-run abandons the run with no done pulse; after release, a new start is required.

Structure
REQ-031 FSM state encoding typedef and the default CNT_W/TIME_W constants SHALL live in shared package step_pkg.
REQ-032 One sub-module, rr_arb2 (combinational 2-way round-robin pick from eligibility and priority), SHALL be instantiated; the counters and FSM stay in step_scheduler.

Verification
REQ-033 count_a=10, count_b=10, req_a=req_b=1, start pulse -> gnt alternates A,B,... for 20 cycles; idx 0,0,1,1,...,9,9; done pulses once; time_cnt=20 at done.
REQ-034 count_a=3, count_b=5, both requesting -> A,B,A,B,A,B,B,B; done after the 8th grant.
REQ-035 count_a=count_b=0 -> no grants; done pulses 2 cycles after start; time_cnt=1.
REQ-036 count_a=4, count_b=4, req_b held low for the first 6 cycles -> A granted 4 consecutive cycles (idx 0-3), then B 4 cycles (idx 0-3); done once.
REQ-037 rst_n pulsed low after 5 grants of a 10/10 run -> outputs go to reset values at once, no done pulse; a following start with 2/2 completes normally with idx restarting at 0.
REQ-038 start re-pulsed mid-run with different counts -> ignored; grant sequence and done timing match the original counts.
